// File: rtl/seg_mux_display.sv
// Multiplexed 7-segment display driver for NUM_DIGITS common-cathode digits.
// The value is double-buffered so it changes only at a frame boundary.
// Each digit can be blanked individually. Brightness is set by PWM.
// The whole display can blink, and a colon output is provided.
module seg_mux_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 3840,
  parameter int BLINK_DIV   = 8000000,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    blink_en,
  input  logic [1:0]              colon_mode,
  output logic [NUM_DIGITS-1:0]   comm,
  output logic [6:0]              seg,
  output logic                    colon,
  output logic                    blink_phase,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int REF_W = $clog2(REFRESH_DIV + 1);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [REF_W-1:0]        ref_cnt;
  logic [BLK_W-1:0]        blink_cnt;
  logic [BRIGHT_BITS-1:0]  pwm_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    slot_tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] staging_val;
  logic [NUM_DIGITS-1:0]   staging_blank;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic [3:0]              nib_p0;
  logic                    pwm_on_p0;
  logic                    lit_p0;
  logic [NUM_DIGITS-1:0]   comm_p0;
  logic [6:0]              seg_p0;
  logic                    colon_p0;

  // Convert a hex digit to its segment pattern, ordered g..a (bit 0 = a).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_tick = (ref_cnt == '0);
  assign wrap      = slot_tick && (idx == IDX_LAST);

  // The slot timer counts down and reloads, so one slot lasts exactly REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) ref_cnt <= REF_LAST;
    else if (slot_tick) ref_cnt <= REF_LAST;
    else ref_cnt <= ref_cnt - 1'b1;
  end

  // Scan index advance. frame_tick is registered together with the index wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (slot_tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Double buffer. Staged data moves to shadow only at a wrap. If a load
  // arrives in the wrap cycle, the older staged value commits and the new
  // load stays pending for the next wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging_val   <= '0;
      staging_blank <= '0;
      pending       <= 1'b0;
      shadow_val    <= '0;
      shadow_blank  <= '0;
    end else begin
      if (wrap && pending) begin
        shadow_val   <= staging_val;
        shadow_blank <= staging_blank;
      end
      if (load) begin
        staging_val   <= value_in;
        staging_blank <= blank_in;
        pending       <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // Free-running PWM counter that wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Blink half-period timer. blink_phase toggles each time the timer reloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= BLK_LAST;
      blink_phase <= 1'b1;
    end else if (blink_cnt == '0) begin
      blink_cnt   <= BLK_LAST;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  // Stage 0: decide whether the current digit is lit, and build the pin values.
  always_comb begin
    nib_p0    = shadow_val[4*idx +: 4];
    pwm_on_p0 = (pwm_cnt < brightness) || (&brightness);
    lit_p0    = pwm_on_p0 && !shadow_blank[idx] && !(blink_en && !blink_phase);
    comm_p0   = lit_p0 ? ~(NUM_DIGITS'(1) << idx) : '1;
    seg_p0    = lit_p0 ? hex_to_seg(nib_p0) : 7'h00;
    case (colon_mode)
      2'b01:   colon_p0 = 1'b1;
      2'b10:   colon_p0 = blink_phase;
      default: colon_p0 = 1'b0;
    endcase
  end

  // Stage 1: registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      comm  <= '1;
      seg   <= 7'h00;
      colon <= 1'b0;
    end else begin
      comm  <= comm_p0;
      seg   <= seg_p0;
      colon <= colon_p0;
    end
  end

endmodule

// File: tb/tb_seg_mux_display.sv
// Testbench for seg_mux_display, using a small configuration (4 digits, 4-cycle slots, 64-cycle blink).
// Expected outputs come from a closed-form model indexed by the number of
// clock edges since reset release, together with a log of the accepted loads.
module tb_seg_mux_display;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BD = 64;
  localparam int BB = 2;
  localparam int RN = R * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   value_in;
  logic [3:0]    blank_in;
  logic          load;
  logic [1:0]    brightness;
  logic          blink_en;
  logic [1:0]    colon_mode;
  logic [3:0]    comm;
  logic [6:0]    seg;
  logic          colon;
  logic          blink_phase;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;

  seg_mux_display #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(BD), .BRIGHT_BITS(BB)
  ) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .blank_in(blank_in),
    .load(load), .brightness(brightness), .blink_en(blink_en),
    .colon_mode(colon_mode), .comm(comm), .seg(seg), .colon(colon),
    .blink_phase(blink_phase), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          e;
    logic [15:0] v;
    logic [3:0]  b;
  } load_t;

  load_t      log_q[$];
  int         k = 0;
  logic [1:0] s_bright;
  logic       s_blink_en;
  logic [1:0] s_colon;
  logic [6:0] seg_tab [16];

  // Count edges since reset release, log accepted loads, and keep the inputs the DUT sampled at the last edge.
  always @(posedge clk) begin
    if (reset) begin
      k <= 0;
      log_q.delete();
    end else begin
      if (load) log_q.push_back('{k, value_in, blank_in});
      k <= k + 1;
    end
    s_bright   <= brightness;
    s_blink_en <= blink_en;
    s_colon    <= colon_mode;
  end

  // Expected {comm, seg, colon, blink_phase, frame_tick} after kk edges since reset.
  function automatic logic [13:0] model(input int kk);
    int j, idx, w;
    logic [15:0] sv;
    logic [3:0]  sb, c, nib;
    logic [6:0]  s;
    logic        ph, lit, col, found;
    if (kk == 0) return {4'hF, 7'h00, 1'b0, 1'b1, 1'b0};
    j   = kk - 1;
    idx = (j / R) % N;
    ph  = ((j / BD) % 2) == 0;
    sv  = '0;
    sb  = '0;
    if (j >= RN) begin
      w = (j / RN) * RN - 1;
      found = 1'b0;
      for (int q = log_q.size() - 1; q >= 0; q--) begin
        if (!found && log_q[q].e < w) begin
          sv = log_q[q].v;
          sb = log_q[q].b;
          found = 1'b1;
        end
      end
    end
    lit = ((j % (1 << BB)) < int'(s_bright) || s_bright == 2'b11) && !sb[idx] && !(s_blink_en && !ph);
    nib = sv[4*idx +: 4];
    c   = lit ? ~(4'b0001 << idx) : 4'hF;
    s   = lit ? seg_tab[nib] : 7'h00;
    col = (s_colon == 2'b01) ? 1'b1 : (s_colon == 2'b10) ? ph : 1'b0;
    return {c, s, col, ((kk / BD) % 2) == 0, (kk % RN) == 0};
  endfunction

  function automatic int low_digit(input logic [3:0] c);
    int d = -1;
    for (int i = N - 1; i >= 0; i--) if (!c[i]) d = i;
    return d;
  endfunction

  task automatic wait_slot(input int p);
    @(negedge clk);
    while (k % RN != p) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== {4'hF, 7'h00, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset: got comm=%b seg=%h colon=%b phase=%b tick=%b, need 1111/00/0/1/0",
                 comm, seg, colon, blink_phase, frame_tick);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_idle;
    logic [13:0] e;
    int ticks = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      e = model(k);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== e) begin
        errors++;
        $display("FAIL idle k=%0d: got %h need %h", k, {comm, seg, colon, blink_phase, frame_tick}, e);
      end
      if (i == 1) begin
        checks++;
        if (comm !== 4'b1110 || seg !== 7'h3F) begin
          errors++;
          $display("FAIL idle_first_slot: got comm=%b seg=%h need 1110/3f", comm, seg);
        end
      end
      if (frame_tick) ticks++;
    end
    checks++;
    if (ticks != 3) begin
      errors++;
      $display("FAIL idle_frame_ticks: got %0d need 3", ticks);
    end
  endtask

  task automatic test_load_midframe;
    logic [13:0] e;
    logic [6:0]  want [4];
    logic        seen = 1'b0;
    int          d;
    want[0] = 7'h71; want[1] = 7'h5B; want[2] = 7'h77; want[3] = 7'h06;
    wait_slot(6);
    value_in = 16'h1A2F; blank_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = model(k);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== e) begin
        errors++;
        $display("FAIL load_mid k=%0d: got %h need %h", k, {comm, seg, colon, blink_phase, frame_tick}, e);
      end
      d = low_digit(comm);
      if (d >= 0) begin
        checks++;
        if (seg !== (seen ? want[d] : 7'h3F)) begin
          errors++;
          $display("FAIL load_mid_digit%0d: got seg=%h need %h", d, seg, seen ? want[d] : 7'h3F);
        end
      end
      if (frame_tick) seen = 1'b1;
    end
  endtask

  task automatic test_back_to_back;
    logic [13:0] e;
    wait_slot(3);
    value_in = 16'h1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_slot(9);
    value_in = 16'h2222; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_slot(15);
    value_in = 16'h3333; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      e = model(k);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== e) begin
        errors++;
        $display("FAIL b2b k=%0d: got %h need %h", k, {comm, seg, colon, blink_phase, frame_tick}, e);
      end
      if (comm !== 4'hF) begin
        checks++;
        if (seg !== ((i <= 16) ? 7'h5B : 7'h4F)) begin
          errors++;
          $display("FAIL b2b_value i=%0d: got seg=%h need %h", i, seg, (i <= 16) ? 7'h5B : 7'h4F);
        end
      end
    end
  endtask

  task automatic test_blank;
    logic [13:0] e;
    logic seen = 1'b0;
    int after = 0, lit_cnt = 0, d2_cnt = 0;
    wait_slot(2);
    value_in = 16'($urandom); blank_in = 4'b0100; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = model(k);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== e) begin
        errors++;
        $display("FAIL blank k=%0d: got %h need %h", k, {comm, seg, colon, blink_phase, frame_tick}, e);
      end
      if (seen && after < 16) begin
        after++;
        if (comm !== 4'hF) lit_cnt++;
        if (comm[2] === 1'b0) d2_cnt++;
      end
      if (frame_tick) seen = 1'b1;
    end
    checks++;
    if (lit_cnt != 12 || d2_cnt != 0) begin
      errors++;
      $display("FAIL blank_counts: got lit=%0d digit2=%0d need 12 and 0", lit_cnt, d2_cnt);
    end
  endtask

  task automatic test_brightness;
    logic [13:0] e;
    int lit_cnt = 0;
    wait_slot(1);
    value_in = 16'($urandom); blank_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (20) @(negedge clk);
    brightness = 2'd1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      e = model(k);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== e) begin
        errors++;
        $display("FAIL bright1 k=%0d: got %h need %h", k, {comm, seg, colon, blink_phase, frame_tick}, e);
      end
      if (comm !== 4'hF) lit_cnt++;
    end
    checks++;
    if (lit_cnt != 8) begin
      errors++;
      $display("FAIL bright1_duty: got %0d lit cycles of 32, need 8", lit_cnt);
    end
    brightness = 2'd0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      checks++;
      if (comm !== 4'hF || seg !== 7'h00) begin
        errors++;
        $display("FAIL bright0 k=%0d: got comm=%b seg=%h need 1111/00", k, comm, seg);
      end
    end
    brightness = 2'd3;
  endtask

  task automatic test_blink;
    logic [13:0] e;
    logic prev_ph;
    int last_t = -1, guard = 0;
    blink_en = 1'b1; colon_mode = 2'b10;
    prev_ph = blink_phase;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      e = model(k);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== e) begin
        errors++;
        $display("FAIL blink k=%0d: got %h need %h", k, {comm, seg, colon, blink_phase, frame_tick}, e);
      end
      if (blink_phase == 1'b0 && prev_ph == 1'b0) begin
        checks++;
        if (comm !== 4'hF || colon !== 1'b0) begin
          errors++;
          $display("FAIL blink_dark k=%0d: got comm=%b colon=%b need 1111/0", k, comm, colon);
        end
      end
      if (blink_phase == 1'b1 && prev_ph == 1'b1) begin
        checks++;
        if (colon !== 1'b1) begin
          errors++;
          $display("FAIL blink_colon k=%0d: got colon=%b need 1", k, colon);
        end
      end
      if (blink_phase !== prev_ph) begin
        if (last_t >= 0) begin
          checks++;
          if (k - last_t != BD) begin
            errors++;
            $display("FAIL blink_period: got %0d need %0d", k - last_t, BD);
          end
        end
        last_t = k;
      end
      prev_ph = blink_phase;
    end
    while (blink_phase !== 1'b0 && guard < 140) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (blink_phase !== 1'b0) begin
      errors++;
      $display("FAIL blink_wait: got phase=%b need 0 within 140 cycles", blink_phase);
    end
    value_in = 16'hBEEF; blank_in = 4'b0000; load = 1'b1;
    @(negedge clk);
    load = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({comm, seg, colon, blink_phase, frame_tick} !== {4'hF, 7'h00, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset: got comm=%b seg=%h colon=%b phase=%b tick=%b, need 1111/00/0/1/0",
               comm, seg, colon, blink_phase, frame_tick);
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = model(k);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== e) begin
        errors++;
        $display("FAIL postreset k=%0d: got %h need %h", k, {comm, seg, colon, blink_phase, frame_tick}, e);
      end
      if (comm !== 4'hF) begin
        checks++;
        if (seg !== 7'h3F) begin
          errors++;
          $display("FAIL postreset_discard: got seg=%h need 3f", seg);
        end
      end
    end
    blink_en = 1'b0; colon_mode = 2'b00;
  endtask

  task automatic test_random;
    logic [13:0] e;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      e = model(k);
      checks++;
      if ({comm, seg, colon, blink_phase, frame_tick} !== e) begin
        errors++;
        $display("FAIL random k=%0d: got %h need %h", k, {comm, seg, colon, blink_phase, frame_tick}, e);
      end
      checks++;
      if ($countones(~comm) > 1) begin
        errors++;
        $display("FAIL onehot k=%0d: got comm=%b need at most one low bit", k, comm);
      end
      load     = ($urandom % 6) == 0;
      value_in = 16'($urandom);
      blank_in = (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000;
      if (($urandom % 40) == 0) brightness = 2'($urandom);
      if (($urandom % 60) == 0) blink_en = 1'($urandom);
      if (($urandom % 30) == 0) colon_mode = 2'($urandom);
    end
    load = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    reset = 1'b1; value_in = '0; blank_in = '0; load = 1'b0;
    brightness = 2'd3; blink_en = 1'b0; colon_mode = 2'b00;
    test_reset();
    test_idle();
    test_load_midframe();
    test_back_to_back();
    test_blank();
    test_brightness();
    test_blink();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
